// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction memory size and the IF/ID record.
package cpu_pkg;

  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned INSTR_MEM_SIZE = 128;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               valid;
  } ifid_t;

  // Word-aligned form of a redirect target.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode-side controls and IF/ID outputs.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  InstrAddr;
  logic [INSTR_W-1:0] Instr;
  logic               Stall;
  logic               Flush;
  logic               RedirValid;
  logic [ADDR_W-1:0]  RedirTarget;
  logic [INSTR_W-1:0] IFID_Instr;
  logic [ADDR_W-1:0]  IFID_PC;
  logic [ADDR_W-1:0]  IFID_PCPlus4;
  logic               IFID_Valid;
  logic               Halted;
  logic               MisalignErr;
  logic [31:0]        FetchCount;

  // master = fetch unit, slave = memory + decode/control side
  modport master (
    output InstrAddr,
    input  Instr,
    input  Stall, Flush, RedirValid, RedirTarget,
    output IFID_Instr, IFID_PC, IFID_PCPlus4, IFID_Valid,
    output Halted, MisalignErr, FetchCount
  );

  modport slave (
    input  InstrAddr,
    output Instr,
    output Stall, Flush, RedirValid, RedirTarget,
    input  IFID_Instr, IFID_PC, IFID_PCPlus4, IFID_Valid,
    input  Halted, MisalignErr, FetchCount
  );

endinterface

// File: rtl/instr_fetch_unit_ifid_reg.sv
// IF/ID pipeline register: bubble beats load, load beats hold; synchronous reset.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR_P = cpu_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic [ADDR_W-1:0] cur_pc,
  input  ifid_t             d,
  output ifid_t             q
);

  ifid_t bubble_val;

  // A bubble still records the PC it replaced so decode can trace flushed slots.
  always_comb begin
    bubble_val          = '0;
    bubble_val.instr    = NOP_INSTR_P;
    bubble_val.pc       = cur_pc;
    bubble_val.pc_plus4 = cur_pc + 32'd4;
    bubble_val.valid    = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= '0;
      q.instr    <= NOP_INSTR_P;
    end else if (bubble) begin
      q <= bubble_val;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and fills IF/ID for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_SIZE  = cpu_pkg::INSTR_MEM_SIZE,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);
  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_SIZE - 4);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              halted;
  logic              misalign;
  logic [31:0]       fetch_cnt;
  logic              in_range;
  logic              stop;
  logic              do_bubble;
  logic              do_load;
  ifid_t             fetch_d;
  ifid_t             ifid_q;

  assign pc_plus4 = pc + 32'd4;
  assign in_range = (pc <= LAST_PC);
  assign stop     = halted | ~in_range;

  // Any of redirect, halt/out-of-range or flush turns this slot into a bubble.
  assign do_bubble = bus.RedirValid | stop | bus.Flush;
  assign do_load   = ~bus.Stall;

  always_comb begin
    fetch_d          = '0;
    fetch_d.instr    = bus.Instr;
    fetch_d.pc       = pc;
    fetch_d.pc_plus4 = pc_plus4;
    fetch_d.valid    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      halted    <= 1'b0;
      misalign  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      misalign <= 1'b0;
      if (bus.RedirValid) begin
        // Halt is cleared here and re-evaluated against the new PC next cycle.
        pc       <= align_word(bus.RedirTarget);
        halted   <= 1'b0;
        misalign <= |bus.RedirTarget[1:0];
      end else if (stop) begin
        halted <= 1'b1;
      end else if (!bus.Stall) begin
        pc <= pc_plus4;
        if (!bus.Flush)
          fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  ifid_reg #(.NOP_INSTR_P(NOP_INSTR)) u_ifid (
    .clk    (clk),
    .rst    (rst),
    .load   (do_load),
    .bubble (do_bubble),
    .cur_pc (pc),
    .d      (fetch_d),
    .q      (ifid_q)
  );

  assign bus.InstrAddr    = pc;
  assign bus.IFID_Instr   = ifid_q.instr;
  assign bus.IFID_PC      = ifid_q.pc;
  assign bus.IFID_PCPlus4 = ifid_q.pc_plus4;
  assign bus.IFID_Valid   = ifid_q.valid;
  assign bus.Halted       = halted;
  assign bus.MisalignErr  = misalign;
  assign bus.FetchCount   = fetch_cnt;

endmodule
